// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control codes used by ALUControl, the ALU and the multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [4:0] OPAND   = 5'd0;
    localparam logic [4:0] OPOR    = 5'd1;
    localparam logic [4:0] OPADD   = 5'd2;
    localparam logic [4:0] OPSUB   = 5'd6;
    localparam logic [4:0] OPSLT   = 5'd7;
    localparam logic [4:0] OPMULT  = 5'd16;
    localparam logic [4:0] OPMULTU = 5'd17;
    localparam logic [4:0] OPDIV   = 5'd18;
    localparam logic [4:0] OPDIVU  = 5'd19;
    localparam logic [4:0] OPMTHI  = 5'd20;
    localparam logic [4:0] OPMTLO  = 5'd21;

    // Signed variants need operand magnitudes and a sign fix-up at the end.
    function automatic logic is_signed_op(input logic [4:0] code);
        return (code == OPMULT) || (code == OPDIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One 64-bit working register and one 33-bit adder serve both the
// shift-add multiply and the restoring divide; results commit in FIX.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic [4:0]        iControlSignal,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    output logic [DATA_W-1:0] oHI,
    output logic [DATA_W-1:0] oLO,
    output logic              oBusy,
    output logic              oDone
);

    localparam int W = DATA_W;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [4:0]      cnt_reg;
    logic [2*W-1:0]  w_reg;
    logic [W-1:0]    b_reg;
    logic            neg_q_reg, neg_r_reg, div0_reg, mul_reg;
    logic [W-1:0]    hi_reg, lo_reg;

    logic            sgn_start;
    logic [W-1:0]    mag_a, mag_b;
    logic            is_div;
    logic [W:0]      rem_sh, add_a, add_b, add_sum;
    logic [2*W-1:0]  w_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    fix_hi, fix_lo;

    // State register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state_reg;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                oDone      = (state_reg == DONE);
                state_next = IDLE;
                if (iStart) begin
                    if (iControlSignal == OPMULT || iControlSignal == OPMULTU)
                        state_next = MUL;
                    else if (iControlSignal == OPDIV || iControlSignal == OPDIVU)
                        state_next = DIV;
                end
            end
            MUL, DIV: begin
                oBusy = 1'b1;
                if (cnt_reg == 5'd31) state_next = FIX;
            end
            FIX: begin
                oBusy      = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes taken at the start edge.
    always_comb begin
        sgn_start = is_signed_op(iControlSignal);
        mag_a     = (sgn_start && iA[W-1]) ? -iA : iA;
        mag_b     = (sgn_start && iB[W-1]) ? -iB : iB;
    end

    // Shared adder: add multiplicand for MUL, subtract divisor for DIV.
    always_comb begin
        is_div  = (state_reg == DIV);
        rem_sh  = w_reg[2*W-1:W-1];
        add_a   = is_div ? rem_sh : {1'b0, w_reg[2*W-1:W]};
        add_b   = is_div ? ~{1'b0, b_reg} : (w_reg[0] ? {1'b0, b_reg} : '0);
        add_sum = add_a + add_b + {{W{1'b0}}, is_div};
        if (is_div) begin
            // Negative difference means the divisor did not fit: restore.
            if (add_sum[W]) w_next = {rem_sh[W-1:0], w_reg[W-2:0], 1'b0};
            else            w_next = {add_sum[W-1:0], w_reg[W-2:0], 1'b1};
        end else begin
            w_next = {add_sum, w_reg[W-1:1]};
        end
    end

    // Sign correction applied to the final working value.
    always_comb begin
        prod_fix = neg_q_reg ? -w_reg : w_reg;
        if (mul_reg) begin
            fix_hi = prod_fix[2*W-1:W];
            fix_lo = prod_fix[W-1:0];
        end else begin
            fix_hi = neg_r_reg ? -w_reg[2*W-1:W] : w_reg[2*W-1:W];
            if (div0_reg)       fix_lo = '1;
            else if (neg_q_reg) fix_lo = -w_reg[W-1:0];
            else                fix_lo = w_reg[W-1:0];
        end
    end

    // Working registers, iteration counter and architectural HI/LO.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt_reg   <= '0;
            w_reg     <= '0;
            b_reg     <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            div0_reg  <= 1'b0;
            mul_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (iStart) begin
                        case (iControlSignal)
                            OPMULT, OPMULTU: begin
                                w_reg     <= {{W{1'b0}}, mag_b};
                                b_reg     <= mag_a;
                                neg_q_reg <= sgn_start & (iA[W-1] ^ iB[W-1]);
                                neg_r_reg <= sgn_start & iA[W-1];
                                div0_reg  <= 1'b0;
                                mul_reg   <= 1'b1;
                                cnt_reg   <= '0;
                            end
                            OPDIV, OPDIVU: begin
                                w_reg     <= {{W{1'b0}}, mag_a};
                                b_reg     <= mag_b;
                                neg_q_reg <= sgn_start & (iA[W-1] ^ iB[W-1]);
                                neg_r_reg <= sgn_start & iA[W-1];
                                div0_reg  <= (iB == '0);
                                mul_reg   <= 1'b0;
                                cnt_reg   <= '0;
                            end
                            OPMTHI:  hi_reg <= iA;
                            OPMTLO:  lo_reg <= iA;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    w_reg   <= w_next;
                    cnt_reg <= cnt_reg + 5'd1;
                end
                FIX: begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign oHI = hi_reg;
    assign oLO = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a transaction-level model of HI/LO,
// busy and done is compared every cycle, plus literal result checks.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  ctrl;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.DATA_W(32)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .iControlSignal(ctrl),
        .iA(a), .iB(b), .oHI(hi), .oLO(lo), .oBusy(busy), .oDone(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain arithmetic.
    task automatic model_calc(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        rh = '0;
        rl = '0;
        if (c == OPMULTU) begin
            p = {32'h0, x} * {32'h0, y};
            rh = p[63:32]; rl = p[31:0];
        end else if (c == OPMULT) begin
            p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            rh = p[63:32]; rl = p[31:0];
        end else if (y == 32'h0) begin
            rh = x; rl = 32'hFFFFFFFF;
        end else if (c == OPDIVU) begin
            rl = x / y; rh = x % y;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            rl = 32'h80000000; rh = 32'h0;
        end else begin
            rl = sx / sy; rh = sx % sy;
        end
    endtask

    // Model: an accepted MULT/DIV commits 33 edges later; done follows.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_remain;
    logic        m_done;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_remain = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                if (ctrl == OPMULT || ctrl == OPMULTU || ctrl == OPDIV || ctrl == OPDIVU) begin
                    model_calc(ctrl, a, b, p_hi, p_lo);
                    m_remain = 33;
                end else if (ctrl == OPMTHI) m_hi = a;
                else if (ctrl == OPMTLO)     m_lo = a;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
        check("cyc_busy", {31'b0, busy}, {31'b0, (m_remain > 0)});
        check("cyc_done", {31'b0, done}, {31'b0, m_done});
    end

    // Issue an operation at the current negedge and wait for its done pulse.
    task automatic run_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                          output int cycles, output int busy_cycles);
        start = 1'b1; ctrl = c; a = x; b = y;
        busy_cycles = 0;
        cycles = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; ctrl = 5'($urandom); a = $urandom; b = $urandom;
            end
            if (busy) busy_cycles++;
            if (done) begin
                cycles = k;
                break;
            end
        end
        if (cycles == 0) check("done_timeout", 32'd0, 32'd1);
        $display("op %0d a=%08h b=%08h -> hi=%08h lo=%08h in %0d cycles", c, x, y, hi, lo, cycles);
    endtask

    task automatic one_shot(input logic [4:0] c, input logic [31:0] x);
        start = 1'b1; ctrl = c; a = x; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        $display("op %0d a=%08h -> hi=%08h lo=%08h", c, x, hi, lo);
    endtask

    int cyc, bcyc;

    initial begin
        rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcyc);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        check("multu_done_cycle", cyc, 32'd34);
        check("multu_busy_cycles", bcyc, 32'd33);

        run_op(OPMULT, 32'hFFFFFFFD, 32'h00000005, cyc, bcyc);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);

        run_op(OPMULT, 32'h80000000, 32'h80000000, cyc, bcyc);
        check("mult_min_hi", hi, 32'h40000000);
        check("mult_min_lo", lo, 32'h00000000);

        run_op(OPMULTU, 32'h12345678, 32'h00000010, cyc, bcyc);
        check("multu2_hi", hi, 32'h00000001);
        check("multu2_lo", lo, 32'h23456780);

        run_op(OPDIV, 32'hFFFFFFF9, 32'h00000002, cyc, bcyc);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        run_op(OPDIV, 32'h00000007, 32'hFFFFFFFE, cyc, bcyc);
        check("div2_lo", lo, 32'hFFFFFFFD);
        check("div2_hi", hi, 32'h00000001);

        run_op(OPDIVU, 32'd1000, 32'd7, cyc, bcyc);
        check("divu_lo", lo, 32'd142);
        check("divu_hi", hi, 32'd6);

        run_op(OPDIVU, 32'h00000064, 32'h0, cyc, bcyc);
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'h00000064);
        check("divu0_cycle", cyc, 32'd34);

        run_op(OPDIV, 32'hFFFFFFF0, 32'h0, cyc, bcyc);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'hFFFFFFF0);

        run_op(OPDIV, 32'h80000000, 32'hFFFFFFFF, cyc, bcyc);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);

        // Unknown code with start: nothing changes.
        one_shot(OPADD, 32'h5A5A5A5A);
        check("noop_hi", hi, 32'h00000000);
        check("noop_lo", lo, 32'h80000000);

        one_shot(OPMTHI, 32'hCAFEF00D);
        check("mthi_hi", hi, 32'hCAFEF00D);

        // MTHI issued mid-divide is ignored.
        start = 1'b1; ctrl = OPDIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; ctrl = OPMTHI; a = 32'hAAAA5555;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin cyc = 1; break; end
        end
        if (cyc == 0) check("mthi_busy_timeout", 32'd0, 32'd1);
        check("mthi_busy_hi", hi, 32'd2);
        check("mthi_busy_lo", lo, 32'd14);
        $display("op div+mthi -> hi=%08h lo=%08h", hi, lo);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; ctrl = OPDIV; a = 32'd12345; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        one_shot(OPMTLO, 32'h00001234);
        check("post_rst_mtlo", lo, 32'h00001234);
        check("post_rst_hi", hi, 32'h0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports are named iCLK and iRST.
REQ-002 The block SHALL have parameter DATA_W, default 32, operand and HI/LO width; only 32 is supported.
REQ-003 The block SHALL have port iCLK, input, 1 bit: clock, rising-edge active.
REQ-004 The block SHALL have port iRST, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port iStart, input, 1 bit: request an operation this cycle.
REQ-006 The block SHALL have port iControlSignal, input, 5 bits: ALU control code from ALUControl; OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI and OPMTLO are acted on.
REQ-007 The block SHALL have port iA, input, 32 bits: rs1 value; multiplicand, dividend, or MTHI/MTLO source.
REQ-008 The block SHALL have port iB, input, 32 bits: rs2 value; multiplier or divisor.
REQ-009 The block SHALL have port oHI, output, 32 bits: architectural HI register, read by the MFHI path.
REQ-010 The block SHALL have port oLO, output, 32 bits: architectural LO register, read by the MFLO path.
REQ-011 The block SHALL have port oBusy, output, 1 bit: an operation is in progress, and the pipeline stalls any HI/LO consumer.
REQ-012 The block SHALL have port oDone, output, 1 bit: one-cycle pulse when a new HI/LO result is committed.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV, FIX and DONE; oBusy=1 in MUL, DIV and FIX only; oDone=1 in DONE only.
REQ-014 In IDLE or DONE with iStart=1, the block SHALL act on iControlSignal as follows:
- MULT or MULTU: go to MUL.
- DIV or DIVU: go to DIV.
- MTHI: HI<=iA at that edge; go to IDLE.
- MTLO: LO<=iA at that edge; go to IDLE.
- Any other code: go to IDLE; nothing changes.
REQ-015 The block SHALL latch iA, iB and the signedness of the operation at the start edge, so later operand changes have no effect.
REQ-016 Signed operations SHALL convert the operands to magnitudes at start and record the result signs.
REQ-017 MUL SHALL run 32 radix-2 shift-add iterations and DIV SHALL run 32 restoring shift-subtract iterations, one per clock, counted by a 5-bit counter.
REQ-018 When the counter equals 31, the iteration edge SHALL move MUL or DIV to FIX.
REQ-019 FIX SHALL apply the sign correction and commit HI/LO in one edge, then move to DONE; DONE SHALL last one cycle and then go to IDLE unless a new iStart is accepted.
REQ-020 Latency SHALL be fixed: HI/LO are updated 33 edges after the start edge, and oDone is high in the following cycle.
REQ-021 Multiply SHALL place the 64-bit product in {HI,LO}.
REQ-022 Divide SHALL place the quotient in LO and the remainder in HI; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-023 Divide by zero (signed or unsigned) SHALL give LO=0xFFFFFFFF and HI=dividend, with the same latency.
REQ-024 Signed overflow, 0x80000000 / 0xFFFFFFFF, SHALL give LO=0x80000000 and HI=0x00000000.
REQ-025 oHI and oLO SHALL hold their previous values throughout MUL, DIV and FIX; working registers are separate from HI/LO.
REQ-026 iStart SHALL be ignored while oBusy=1, for all codes including MTHI and MTLO.
REQ-027 iControlSignal SHALL be ignored when iStart=0.

Reset
REQ-028 iRST=1 SHALL immediately force state IDLE, counter 0, all working registers 0, oHI=0, oLO=0, oBusy=0 and oDone=0.
REQ-029 A reset during MUL, DIV or FIX SHALL abandon the operation with no partial HI/LO commit; the first edge after reset release accepts iStart normally.

Structure
REQ-030 The 5-bit OP* control codes SHALL come from the shared package also used by ALUControl and the ALU; the block SHALL NOT redefine them locally.
REQ-031 The FSM state encoding SHALL be a local typedef, not in the package.
REQ-032 No sub-module is required; the multiply and divide iterations SHALL share one 64-bit working register and one 33-bit adder/subtractor.

Verification
REQ-033 MULTU with iA=0xFFFFFFFF, iB=0xFFFFFFFF SHALL give HI=0xFFFFFFFE and LO=0x00000001, with oDone high exactly 34 cycles after the start cycle and oBusy high for 33 cycles.
REQ-034 MULT with iA=0xFFFFFFFD (-3), iB=0x00000005 SHALL give HI=0xFFFFFFFF and LO=0xFFFFFFF1.
REQ-035 DIV with iA=0xFFFFFFF9 (-7), iB=0x00000002 SHALL give LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-036 DIVU with iA=0x00000064, iB=0 SHALL give LO=0xFFFFFFFF and HI=0x00000064; DIV with iA=0x80000000, iB=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-037 MTHI of 0xAAAA5555 issued 5 cycles into a DIV SHALL be ignored, and HI SHALL equal the divide remainder at commit.
REQ-038 Asserting iRST 10 cycles into a DIV SHALL give HI=LO=0 and oBusy=0 immediately; a following MTLO with iA=0x00001234 SHALL give LO=0x00001234 after one edge.
